// File: rtl/kolache_alu_pkg.sv
// kolache_alu_pkg: shared types and constants for the ALU compare blocks.
//   seq_gt_state_t : FSM state encoding for seq_gt_32b (IDLE, SCAN, DONE)
//   SEQ_GT_WIDTH   : default operand width of seq_gt_32b
//   SEQ_GT_DIGIT   : default number of bits compared per cycle
`timescale 1ns/1ps
package kolache_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } seq_gt_state_t;

  localparam int SEQ_GT_WIDTH = 32;
  localparam int SEQ_GT_DIGIT = 4;

endpackage

// File: rtl/gt_digit.sv
// gt_digit: purely combinational unsigned compare of one DIGIT-bit digit.
//   a_dig, b_dig : digit of operand A / operand B
//   dig_gt       : a_dig > b_dig
//   dig_eq       : a_dig == b_dig
`timescale 1ns/1ps
module gt_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_dig,
  input  logic [DIGIT-1:0] b_dig,
  output logic             dig_gt,
  output logic             dig_eq
);

  assign dig_gt = (a_dig > b_dig);
  assign dig_eq = (a_dig == b_dig);

endmodule

// File: rtl/seq_gt_32b.sv
// seq_gt_32b: multi-cycle magnitude comparator (A > B, A == B).
// Scans the registered operands MSB digit first, one DIGIT-bit digit per
// cycle, and stops at the first differing digit. Valid/ready on both sides.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake; a, b, signed_op sampled on accept
//   out_valid/out_ready : result handshake; gt, eq valid while out_valid=1
// Optional feature macro: SEQ_GT_SIGNED_EN enables the two's-complement
// compare selected by signed_op; without it signed_op is ignored.
`timescale 1ns/1ps
module seq_gt_32b
  import kolache_alu_pkg::*;
#(
  parameter int WIDTH = SEQ_GT_WIDTH,
  parameter int DIGIT = SEQ_GT_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NDIG - 1);

  seq_gt_state_t    state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] idx;

  logic [WIDTH-1:0] a_load;
  logic [WIDTH-1:0] b_load;

`ifdef SEQ_GT_SIGNED_EN
  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so the same digit scan serves both compares.
  localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};
  assign a_load = signed_op ? (a ^ SIGN_BIT) : a;
  assign b_load = signed_op ? (b ^ SIGN_BIT) : b;
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign a_load = a;
  assign b_load = b;
`endif

  // Split the registered operands into digits and pick the current one.
  logic [DIGIT-1:0] a_digs [NDIG];
  logic [DIGIT-1:0] b_digs [NDIG];

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digs
      assign a_digs[gi] = a_q[gi*DIGIT +: DIGIT];
      assign b_digs[gi] = b_q[gi*DIGIT +: DIGIT];
    end
  endgenerate

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic             dig_gt;
  logic             dig_eq;

  assign a_dig = a_digs[idx];
  assign b_dig = b_digs[idx];

  gt_digit #(
    .DIGIT (DIGIT)
  ) u_gt_digit (
    .a_dig  (a_dig),
    .b_dig  (b_dig),
    .dig_gt (dig_gt),
    .dig_eq (dig_eq)
  );

  // Gated with rst so no accept is advertised while reset is asserted.
  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      out_valid <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a_load;
            b_q   <= b_load;
            idx   <= IDX_TOP;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (!dig_eq) begin
            gt        <= dig_gt;
            eq        <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (idx == '0) begin
            gt        <= 1'b0;
            eq        <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
